// File: rtl/integral_decode.sv
// Inverse integral image: S(y,x) raster stream in, pixel P(y,x) stream out.
// Two register stages (output 2 cycles after the sample), no backpressure; idle cycles hold all state.
module integral_decode #(
  parameter int W        = 8,
  parameter int W_SUM    = 16,
  parameter int ROW_SIZE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [W_SUM-1:0] in_sum,
  output logic             out_valid,
  output logic [W-1:0]     pixel,
  output logic             out_last,
  output logic             range_err
);

  localparam int XW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam logic [XW-1:0] LAST_IDX = XW'(ROW_SIZE - 1);

  logic [XW-1:0]    x, y, cx, cy;
  logic [W_SUM-1:0] lb [ROW_SIZE];
  logic [W_SUM-1:0] left_q, upleft_q, up_raw;

  logic             s1_vld, s1_last, s1_top, s1_lft;
  logic [W_SUM-1:0] s1_sum, s1_up, s1_left, s1_upleft;

  logic [W_SUM-1:0] up_m, left_m, upleft_m, d;

  // A start-of-frame sample is pinned to (0,0) whatever the counters say.
  always_comb begin
    cx     = in_sof ? '0 : x;
    cy     = in_sof ? '0 : y;
    up_raw = lb[cx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      left_q    <= '0;
      upleft_q  <= '0;
      for (int i = 0; i < ROW_SIZE; i++) lb[i] <= '0;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s1_top    <= 1'b0;
      s1_lft    <= 1'b0;
      s1_sum    <= '0;
      s1_up     <= '0;
      s1_left   <= '0;
      s1_upleft <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        lb[cx]    <= in_sum;
        left_q    <= in_sum;
        upleft_q  <= up_raw;
        s1_sum    <= in_sum;
        s1_up     <= up_raw;
        s1_left   <= left_q;
        s1_upleft <= upleft_q;
        s1_top    <= (cy == '0);
        s1_lft    <= (cx == '0);
        s1_last   <= (cx == LAST_IDX) && (cy == LAST_IDX);
        if (cx == LAST_IDX) begin
          x <= '0;
          y <= (cy == LAST_IDX) ? '0 : cy + XW'(1);
        end else begin
          x <= cx + XW'(1);
          y <= cy;
        end
      end
    end
  end

  // Stale neighbour values are masked here rather than cleared, so frames can abut.
  always_comb begin
    up_m     = s1_top ? '0 : s1_up;
    left_m   = s1_lft ? '0 : s1_left;
    upleft_m = (s1_top || s1_lft) ? '0 : s1_upleft;
    d        = s1_sum - up_m - left_m + upleft_m;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      range_err <= 1'b0;
      pixel     <= '0;
    end else begin
      out_valid <= s1_vld;
      out_last  <= s1_vld & s1_last;
      range_err <= s1_vld & (|d[W_SUM-1:W]);
      if (s1_vld) pixel <= d[W-1:0];
    end
  end

endmodule

// File: tb/tb_integral_decode.sv
// Directed bench for integral_decode with a timestamped expectation queue.
module tb_integral_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [15:0] in_sum = '0;
  logic        out_valid;
  logic [7:0]  pixel;
  logic        out_last;
  logic        range_err;

  integral_decode #(.W(8), .W_SUM(16), .ROW_SIZE(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_sum(in_sum),
    .out_valid(out_valid), .pixel(pixel), .out_last(out_last), .range_err(range_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] pix;
    logic       err;
    logic       last;
    int         ocyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   lasts = 0;

  logic [15:0] ns [16] = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd6, 16'd14, 16'd24, 16'd36,
                           16'd7, 16'd17, 16'd30, 16'd46, 16'd12, 16'd28, 16'd48, 16'd72};
  logic [7:0]  np [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                           8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Output checker: every falling edge, out_valid must match whether an expectation is due.
  always @(negedge clock) begin
    logic ev;
    exp_t e;
    ev = (q.size() > 0) && (q[0].ocyc <= cyc);
    check("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev) begin
      e = q.pop_front();
      if (out_valid) begin
        check("pixel", {24'd0, pixel}, {24'd0, e.pix});
        check("range_err", {31'd0, range_err}, {31'd0, e.err});
        check("out_last", {31'd0, out_last}, {31'd0, e.last});
      end
    end
    if (out_valid) pulses++;
    if (out_valid && out_last) lasts++;
  end

  task automatic feed(input logic [15:0] s, input logic sof, input logic [7:0] p,
                      input logic e, input logic l);
    exp_t x;
    @(negedge clock);
    in_valid = 1'b1;
    in_sof   = sof;
    in_sum   = s;
    x.pix = p; x.err = e; x.last = l; x.ocyc = cyc + 2;
    q.push_back(x);
  endtask

  task automatic idle(input int n, input logic sof);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_sof   = (i == 0) ? sof : 1'b0;
      in_sum   = 16'hBEEF;
    end
  endtask

  task automatic frame(input logic first_sof, input logic gapped);
    for (int i = 0; i < 16; i++) begin
      feed(ns[i], first_sof && (i == 0), np[i], 1'b0, i == 15);
      if (gapped && (i % 2 == 1)) idle(3, 1'b1);
    end
  endtask

  initial begin
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pixel", {24'd0, pixel}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_err", {31'd0, range_err}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // nominal frame, no sof, counters start from reset
    frame(1'b0, 1'b0);
    idle(4, 1'b0);

    // gapped frame; in_sof pulses while in_valid is low must be ignored
    pulses = 0;
    frame(1'b0, 1'b1);
    idle(4, 1'b0);
    check("gap_pulses", pulses, 32'd16);

    // back-to-back frames, second starts with sof
    pulses = 0; lasts = 0;
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    idle(4, 1'b0);
    check("b2b_pulses", pulses, 32'd32);
    check("b2b_lasts", lasts, 32'd2);

    // mid-frame resync after 6 samples
    lasts = 0;
    for (int i = 0; i < 6; i++) feed(ns[i], 1'b0, np[i], 1'b0, 1'b0);
    frame(1'b1, 1'b0);
    idle(4, 1'b0);
    check("resync_lasts", lasts, 32'd1);

    // range error: 300 overflows 8 bits, 301-300 does not
    feed(16'd300, 1'b1, 8'd44, 1'b1, 1'b0);
    feed(16'd301, 1'b0, 8'd1, 1'b0, 1'b0);
    idle(4, 1'b0);

    // async reset with two samples in flight
    feed(ns[0], 1'b1, np[0], 1'b0, 1'b0);
    feed(ns[1], 1'b0, np[1], 1'b0, 1'b0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("inflight_valid", {31'd0, out_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pixel", {24'd0, pixel}, 32'd0);
    q.delete();
    @(posedge clock);
    #2 reset = 1'b0;
    pulses = 0;
    frame(1'b0, 1'b0);
    idle(5, 1'b0);
    check("post_rst_pulses", pulses, 32'd16);
    check("drain", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
